// File: rtl/alu_seq_k2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_seq_k2 : registered ALU with iterative shift-add multiplier  Rev 1.0 |
// +--------------------------------------------------------------------------+
module alu_seq_k2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] RA,
  input  logic [WIDTH-1:0] RB,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             out_valid,
  output logic             carry_out,
  output logic             zero_flag,
  output logic             neg_flag,
  output logic             ovf_flag,
  output logic             busy
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);
  localparam logic [2:0]     OP_MUL   = 3'b111;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic   accept, mul_last;

  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc, mcand, acc_step;
  logic [WIDTH-1:0]     mplier;

  logic [WIDTH:0]       sum, diff;
  logic [WIDTH-1:0]     res;
  logic                 res_c, res_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    mul_last  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && op == OP_MUL) state_nxt = MUL_RUN;
      end
      MUL_RUN: begin
        busy = 1'b1;
        if (cnt == LAST_CNT) begin
          mul_last  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle result and flags; SUB carry is the borrow out of the extended difference.
  always_comb begin
    sum   = {1'b0, RA} + {1'b0, RB};
    diff  = {1'b0, RA} - {1'b0, RB};
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op)
      3'b000: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (RA[WIDTH-1] == RB[WIDTH-1]) && (sum[WIDTH-1] != RA[WIDTH-1]);
      end
      3'b001: begin
        res   = diff[WIDTH-1:0];
        res_c = diff[WIDTH];
        res_v = (RA[WIDTH-1] != RB[WIDTH-1]) && (diff[WIDTH-1] != RA[WIDTH-1]);
      end
      3'b010: res = RA & RB;
      3'b011: res = RA | RB;
      3'b100: res = RA ^ RB;
      3'b101: begin
        res   = {RA[WIDTH-2:0], 1'b0};
        res_c = RA[WIDTH-1];
      end
      3'b110: begin
        res   = {1'b0, RA[WIDTH-1:1]};
        res_c = RA[0];
      end
      default: ;
    endcase
  end

  assign acc_step = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_hi    <= '0;
      out_valid <= 1'b0;
      carry_out <= 1'b0;
      zero_flag <= 1'b0;
      neg_flag  <= 1'b0;
      ovf_flag  <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        if (op == OP_MUL) begin
          acc    <= '0;
          mcand  <= {{WIDTH{1'b0}}, RA};
          mplier <= RB;
          cnt    <= '0;
        end else begin
          out       <= res;
          out_hi    <= '0;
          carry_out <= res_c;
          zero_flag <= (res == '0);
          neg_flag  <= res[WIDTH-1];
          ovf_flag  <= res_v;
          out_valid <= 1'b1;
        end
      end else if (busy) begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        // The last step's sum is the full product; publish it directly.
        if (mul_last) begin
          out       <= acc_step[WIDTH-1:0];
          out_hi    <= acc_step[2*WIDTH-1:WIDTH];
          carry_out <= |acc_step[2*WIDTH-1:WIDTH];
          zero_flag <= (acc_step == '0);
          neg_flag  <= acc_step[WIDTH-1];
          ovf_flag  <= 1'b0;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/alu_seq_k2.md
ALU_SEQ_K2 -- requirements
Module: alu_seq_k2

Interface
REQ-001 SHALL provide parameter: WIDTH, 8, operand/result width in bits (>= 4).
REQ-002 SHALL provide port: clk  input  1  rising-edge clock, the sole clock.
REQ-003 SHALL provide port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port: RA  input  WIDTH  operand A.
REQ-005 SHALL provide port: RB  input  WIDTH  operand B.
REQ-006 SHALL provide port: op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
REQ-007 SHALL provide port: in_valid  input  1  operands and op present.
REQ-008 SHALL provide port: in_ready  output  1  block can accept an operation.
REQ-009 SHALL provide port: out  output  WIDTH  registered result; for MUL, product low half.
REQ-010 SHALL provide port: out_hi  output  WIDTH  MUL product high half; all zeros for other ops.
REQ-011 SHALL provide port: out_valid  output  1  one-cycle pulse marking a new result.
REQ-012 SHALL provide port: carry_out  output  1  registered carry/borrow flag.
REQ-013 SHALL provide port: zero_flag  output  1  registered zero flag.
REQ-014 SHALL provide port: neg_flag  output  1  registered sign flag, equal to out[WIDTH-1].
REQ-015 SHALL provide port: ovf_flag  output  1  registered signed-overflow flag.
REQ-016 SHALL provide port: busy  output  1  multiply in progress.

Function
REQ-017 SHALL accept an operation on a rising edge where in_valid and in_ready are both 1; all other in_valid cycles are ignored.
REQ-018 SHALL implement FSM states IDLE, MUL_RUN; in_ready = (state == IDLE); busy = (state == MUL_RUN).
REQ-019 SHALL complete ops 000-110 in one cycle: result and flags registered on the accepting edge; out_valid high for the following cycle only; state remains IDLE.
REQ-020 SHALL implement ADD as RA+RB mod 2^WIDTH; carry_out = bit WIDTH of the (WIDTH+1)-bit sum; ovf_flag = signed two's-complement overflow.
REQ-021 SHALL implement SUB as RA-RB mod 2^WIDTH; carry_out = 1 when RA < RB unsigned (borrow); ovf_flag = signed overflow.
REQ-022 SHALL implement AND/OR/XOR bitwise with carry_out = 0, ovf_flag = 0.
REQ-023 SHALL implement SHL/SHR as 1-bit logical shifts of RA (RB ignored), 0 shifted in; carry_out = bit shifted out; ovf_flag = 0.
REQ-024 SHALL implement MUL as unsigned iterative shift-add: accept moves IDLE->MUL_RUN, one partial-product step per cycle for WIDTH cycles, then MUL_RUN->IDLE with {out_hi,out} = RA*RB latched from the accepting edge.
REQ-025 SHALL assert out_valid for MUL exactly WIDTH+1 cycles after the accepting edge, for one cycle.
REQ-026 SHALL set MUL flags: zero_flag = (full 2*WIDTH product == 0), carry_out = (out_hi != 0), neg_flag = out[WIDTH-1], ovf_flag = 0.
REQ-027 SHALL compute zero_flag = (out == 0) for ops 000-110, on the WIDTH-bit result only.
REQ-028 SHALL hold out, out_hi and all flags unchanged between results, including throughout MUL_RUN.
REQ-029 SHALL ignore changes on RA, RB, op during MUL_RUN.
REQ-030 SHALL allow back-to-back single-cycle ops on consecutive edges, each producing its own out_valid pulse.

Reset
REQ-031 SHALL, while rst = 1, immediately force state IDLE, out = 0, out_hi = 0, out_valid = 0, carry_out = 0, zero_flag = 0, neg_flag = 0, ovf_flag = 0, busy = 0, independent of clk.
REQ-032 SHALL abort any multiply on reset with no out_valid pulse, and accept a new op on the first edge after rst deasserts.

Verification (WIDTH = 8)
REQ-033 SHALL verify ADD 0xFF+0x01 -> next cycle out=0x00, carry_out=1, zero_flag=1, ovf_flag=0, out_valid=1 for one cycle.
REQ-034 SHALL verify ADD 0x7F+0x01 -> out=0x80, neg_flag=1, ovf_flag=1, carry_out=0; SUB 0x05-0x07 -> out=0xFE, carry_out=1, neg_flag=1.
REQ-035 SHALL verify MUL 0x0F*0x11 -> in_ready=0 for 8 cycles, out_valid 9 cycles after accept, out=0xFF, out_hi=0x00, carry_out=0; MUL 0xFF*0xFF -> out=0x01, out_hi=0xFE, carry_out=1.
REQ-036 SHALL verify in_valid with ADD during MUL_RUN -> ignored, MUL result and timing unchanged, no extra out_valid.
REQ-037 SHALL verify rst asserted 4 cycles into MUL -> all outputs 0 asynchronously, no out_valid, in_ready=1 after release, next ADD 0x02+0x03 -> out=0x05.
REQ-038 SHALL verify SHL 0x81 -> out=0x02, carry_out=1; SHR 0x01 -> out=0x00, carry_out=1, zero_flag=1; back-to-back AND/OR/XOR produce three consecutive out_valid pulses.
